puf_challenge_sequencer: RTL
============================

# puf_challenge_sequencer

Sequences the arbiter-PUF delay-chain datapath for the AXI4-Lite peripheral: takes a base challenge from the register file, clears the arbiter, fires the launch edge, waits for settling and samples the arbiter output. It then steps the challenge through an LFSR and repeats until a RESP_W-bit response word is assembled. Sits between the slave register block and the PUF fabric instance.

## Interface
- CHAL_W, 64: challenge width (fixed LFSR taps below assume 64)
- RESP_W, 32: response bits produced per request
- SETTLE_CYC, 8: cycles between launch and sample, ≥1
- VOTES, 5: evaluations per bit when majority voting is enabled; odd, ≥1

- ACLK  in  1  sole clock
- ARESET  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- abort  in  1  cancels an operation in progress
- challenge_in  in  CHAL_W  base challenge, captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when response is updated
- response  out  RESP_W  last completed response word
- puf_challenge  out  CHAL_W  challenge driven into delay chains
- puf_clear  out  1  holds arbiter latches in reset
- puf_launch  out  1  one-cycle launch pulse into both chains
- puf_resp  in  1  arbiter output, already synchronised into ACLK

## Operation
- States: IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, NEXT, DONE.
- IDLE: puf_clear=1. start=1 and abort=0: capture challenge_in into the LFSR, clear bit counter, vote counter and ones counter, go to CLEAR.
  - If the captured challenge is all-zero, load 64'h1 instead.
- CLEAR: puf_clear=1 for 2 cycles, then LAUNCH.
- LAUNCH: puf_clear=0, puf_launch=1 for 1 cycle, then SETTLE.
- SETTLE: SETTLE_CYC cycles, then SAMPLE.
- SAMPLE: 1 cycle; ones += puf_resp, vote count += 1.
  - If further votes remain: go to CLEAR.
  - Otherwise: go to NEXT.
- NEXT: 1 cycle.
  - Resolved bit = (ones > VOTES/2).
  - Shift the bit into the internal accumulator LSB (first bit ends at MSB).
  - Step the LFSR: shift left; bit0 = c[63]^c[62]^c[60]^c[59].
  - Clear vote and ones counters.
  - If RESP_W bits are done: go to DONE. Otherwise: go to CLEAR.
- DONE: 1 cycle; copy the accumulator to response, done=1, go to IDLE.
- puf_challenge = LFSR value. Stable across all evaluations of one bit; changes only on the NEXT edge.
- abort=1 in any non-IDLE state:
  - next state IDLE, puf_launch=0, puf_clear=1.
  - response is unchanged and done is not pulsed.
  - abort in DONE is ignored; DONE completes.
- start while busy is ignored and not queued. start and abort in the same IDLE cycle: abort wins.
- Counter widths: bit counter clog2(RESP_W+1), vote and ones counters clog2(VOTES+1). There is no wrap inside an operation.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, response=0.
  - puf_challenge=0, puf_launch=0, puf_clear=1.
  - All counters 0.
- All outputs are registered.
- Start accepted at edge k → busy=1 from cycle k+1.
- Per evaluation: SETTLE_CYC+4 cycles. Per bit: V·(SETTLE_CYC+4)+1 cycles.
- done high in cycle k+1+RESP_W·(V·(SETTLE_CYC+4)+1); busy=0 the following cycle.
  - V=VOTES with the macro, 1 without.
  - Defaults: k+1953 with the macro, k+417 without.
- puf_resp is sampled on the SAMPLE-state edge only. Its value in other cycles is don't-care.
- ARESET mid-operation: next cycle shows reset values, including response=0.

## Configuration
- PUF_MAJORITY_VOTE_EN defined:
  - each bit is evaluated VOTES times and majority-resolved;
  - the vote and ones counters exist.
- Undefined:
  - one evaluation per bit; the resolved bit is the SAMPLE-edge puf_resp;
  - the VOTES parameter is ignored and the counters are removed.

## Test plan
- Params RESP_W=4, SETTLE_CYC=2, VOTES=3, macro on. challenge_in=64'h1, puf_resp tied 1, start at k → exactly 12 puf_launch pulses, done at k+77, response=4'hF.
- Same params, model returns 1,0,1 then 0,0,1 then 1,1,0 then 0,0,0 per bit → response=4'b1010.
- challenge_in=0 → first puf_challenge=64'h1, second=64'h2; challenge_in=64'h8000_0000_0000_0000 → second=64'h1.
- Abort in SETTLE of bit 2 after a prior response 4'h5 → busy=0 next cycle, no done, response stays 4'h5, puf_clear=1.
- Macro off, defaults, puf_resp tied 0 → done at k+417, response=0. start during busy is ignored (only one done).
- ARESET asserted in SAMPLE → all outputs at reset values next cycle; a fresh start then completes normally.

Source files
------------

// File: rtl/puf_challenge_sequencer_if.sv
// Handshake and datapath bundle between the register block, the challenge
// sequencer and the arbiter-PUF fabric.
// slave: the sequencer side. master: the register block / fabric side.
interface puf_challenge_sequencer_if #(
    parameter int unsigned CHAL_W = 64,
    parameter int unsigned RESP_W = 32
);
    logic              start;
    logic              abort;
    logic [CHAL_W-1:0] challenge_in;
    logic              busy;
    logic              done;
    logic [RESP_W-1:0] response;
    logic [CHAL_W-1:0] puf_challenge;
    logic              puf_clear;
    logic              puf_launch;
    logic              puf_resp;

    modport slave (
        input  start, abort, challenge_in, puf_resp,
        output busy, done, response, puf_challenge, puf_clear, puf_launch
    );

    modport master (
        output start, abort, challenge_in, puf_resp,
        input  busy, done, response, puf_challenge, puf_clear, puf_launch
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: clears the arbiter, launches the edge,
// waits for settling, samples the arbiter and assembles a RESP_W-bit word,
// stepping the challenge through a 64-bit LFSR after every resolved bit.
// Optional feature macro: PUF_MAJORITY_VOTE_EN (evaluate each bit VOTES
// times and resolve it by majority). Undefined: one evaluation per bit.
module puf_challenge_sequencer #(
    parameter int unsigned CHAL_W     = 64,
    parameter int unsigned RESP_W     = 32,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned VOTES      = 5
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    puf_challenge_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLaunch,
        StSettle,
        StSample,
        StNext,
        StDone
    } state_e;

    localparam int unsigned BitW   = $clog2(RESP_W + 1);
    // One counter serves both the 2-cycle clear and the settle wait.
    localparam int unsigned CycMax = (SETTLE_CYC > 2) ? SETTLE_CYC : 2;
    localparam int unsigned CycW   = $clog2(CycMax);

    // Parameter sanity: ties are impossible only with an odd vote count.
    if (RESP_W < 1 || SETTLE_CYC < 1 || VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_params
        $error("puf_challenge_sequencer: invalid RESP_W/SETTLE_CYC/VOTES");
    end

    state_e              state_q, state_d;
    logic [CHAL_W-1:0]   lfsr_q, lfsr_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CycW-1:0]     cyc_cnt_q, cyc_cnt_d;
    logic [RESP_W-1:0]   acc_q, acc_d;
    logic [RESP_W-1:0]   response_q, response_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clear_q, clear_d;
    logic                launch_q, launch_d;

    logic                start_acc;
    logic                abort_op;
    logic                last_vote;
    logic                resolved_bit;

    assign start_acc = (state_q == StIdle) && bus.start && !bus.abort;
    // Abort in DONE is ignored so a finished word is never lost.
    assign abort_op  = bus.abort && (state_q != StIdle) && (state_q != StDone);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned VoteW = $clog2(VOTES + 1);

    logic [VoteW-1:0] vote_cnt_q, vote_cnt_d;
    logic [VoteW-1:0] ones_cnt_q, ones_cnt_d;

    // Tally votes and ones for the current bit; cleared on start and after each bit.
    always_comb begin
        vote_cnt_d = vote_cnt_q;
        ones_cnt_d = ones_cnt_q;
        if (start_acc || (state_q == StNext)) begin
            vote_cnt_d = '0;
            ones_cnt_d = '0;
        end else if ((state_q == StSample) && !abort_op) begin
            vote_cnt_d = vote_cnt_q + VoteW'(1);
            ones_cnt_d = ones_cnt_q + VoteW'(bus.puf_resp);
        end
    end

    assign last_vote    = (vote_cnt_q == VoteW'(VOTES - 1));
    assign resolved_bit = (ones_cnt_q > VoteW'(VOTES / 2));

    // Vote tally registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            vote_cnt_q <= '0;
            ones_cnt_q <= '0;
        end else begin
            vote_cnt_q <= vote_cnt_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end
`else
    logic sample_q, sample_d;

    // Hold the single SAMPLE-edge arbiter value until NEXT consumes it.
    always_comb begin
        sample_d = sample_q;
        if (start_acc) begin
            sample_d = 1'b0;
        end else if ((state_q == StSample) && !abort_op) begin
            sample_d = bus.puf_resp;
        end
    end

    assign last_vote    = 1'b1;
    assign resolved_bit = sample_q;

    // Sampled arbiter bit register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= sample_d;
        end
    end
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        acc_d      = acc_q;
        response_d = response_q;

        if (abort_op) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_acc) begin
                        state_d   = StClear;
                        // An all-zero seed would lock the LFSR at zero.
                        lfsr_d    = (bus.challenge_in == '0) ? CHAL_W'(1) : bus.challenge_in;
                        bit_cnt_d = '0;
                        cyc_cnt_d = '0;
                    end
                end
                StClear: begin
                    if (cyc_cnt_q == CycW'(1)) begin
                        state_d   = StLaunch;
                        cyc_cnt_d = '0;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + CycW'(1);
                    end
                end
                StLaunch: begin
                    state_d   = StSettle;
                    cyc_cnt_d = '0;
                end
                StSettle: begin
                    if (cyc_cnt_q == CycW'(SETTLE_CYC - 1)) begin
                        state_d   = StSample;
                        cyc_cnt_d = '0;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + CycW'(1);
                    end
                end
                StSample: begin
                    state_d   = last_vote ? StNext : StClear;
                    cyc_cnt_d = '0;
                end
                StNext: begin
                    acc_d     = (acc_q << 1) | RESP_W'(resolved_bit);
                    lfsr_d    = {lfsr_q[CHAL_W-2:0],
                                 lfsr_q[CHAL_W-1] ^ lfsr_q[CHAL_W-2] ^
                                 lfsr_q[CHAL_W-4] ^ lfsr_q[CHAL_W-5]};
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(RESP_W - 1)) begin
                        state_d    = StDone;
                        // Publish on entry to DONE so response is valid with done.
                        response_d = (acc_q << 1) | RESP_W'(resolved_bit);
                    end else begin
                        state_d = StClear;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        clear_d  = (state_d == StIdle) || (state_d == StClear);
        launch_d = (state_d == StLaunch);
    end

    // State, datapath and output registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= StIdle;
            lfsr_q     <= '0;
            bit_cnt_q  <= '0;
            cyc_cnt_q  <= '0;
            acc_q      <= '0;
            response_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clear_q    <= 1'b1;
            launch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            bit_cnt_q  <= bit_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            acc_q      <= acc_d;
            response_q <= response_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clear_q    <= clear_d;
            launch_q   <= launch_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.response      = response_q;
    assign bus.puf_challenge = lfsr_q;
    assign bus.puf_clear     = clear_q;
    assign bus.puf_launch    = launch_q;

endmodule
